// File: rtl/iob_timer_reader.sv
// IOb initiator that runs timer register sequences for a local client and
// assembles the 64-bit timer value from the LOW/HIGH data registers.
module iob_timer_reader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR     = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] ENABLE_ADDR    = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] SAMPLE_ADDR    = ADDR_W'(2),
  parameter logic [ADDR_W-1:0] DATA_LOW_ADDR  = ADDR_W'(3),
  parameter logic [ADDR_W-1:0] DATA_HIGH_ADDR = ADDR_W'(4),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  output logic                  cmd_ready,
  output logic                  done,
  output logic                  err,
  output logic [2*DATA_W-1:0]   value,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ready
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW:0] TO_LIM = (TW+1)'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, REQ, GAP, FIN} state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [1:0]        step;
  logic [TW-1:0]     tcnt;
  logic [DATA_W-1:0] shadow_low;

  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_op;
  logic [1:0]        sel_step;
  logic [1:0]        last_step;
  logic              timeout_hit;

  // Transaction table: in IDLE it describes step 0 of the incoming command,
  // otherwise the step currently pointed to by the latched command.
  always_comb begin
    sel_op    = (state == IDLE) ? cmd_op : op_q;
    sel_step  = (state == IDLE) ? 2'd0 : step;
    sel_wr    = 1'b1;
    sel_addr  = ENABLE_ADDR;
    sel_wdata = '0;
    case (sel_op)
      2'd0: begin
        case (sel_step)
          2'd0: begin sel_addr = SAMPLE_ADDR; sel_wdata = DATA_W'(1); end
          2'd1: sel_addr = SAMPLE_ADDR;
          2'd2: begin sel_wr = 1'b0; sel_addr = DATA_LOW_ADDR; end
          default: begin sel_wr = 1'b0; sel_addr = DATA_HIGH_ADDR; end
        endcase
      end
      2'd1: sel_wdata = DATA_W'(1);
      2'd2: sel_wdata = '0;
      default: begin
        sel_addr  = RESET_ADDR;
        sel_wdata = (sel_step == 2'd0) ? DATA_W'(1) : '0;
      end
    endcase
    case (op_q)
      2'd0:    last_step = 2'd3;
      2'd3:    last_step = 2'd1;
      default: last_step = 2'd0;
    endcase
    timeout_hit = (TIMEOUT_CYC != 0) && (({1'b0, tcnt} + (TW+1)'(1)) == TO_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= 2'd0;
      step       <= 2'd0;
      tcnt       <= '0;
      shadow_low <= '0;
      cmd_ready  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      value      <= '0;
      m_valid    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            step      <= 2'd0;
            tcnt      <= '0;
            m_valid   <= 1'b1;
            m_addr    <= sel_addr;
            m_wdata   <= sel_wr ? sel_wdata : '0;
            m_wstrb   <= sel_wr ? '1 : '0;
            cmd_ready <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          // A response in the cycle the timeout would fire still counts as success.
          if (m_ready) begin
            m_valid <= 1'b0;
            if (op_q == 2'd0 && step == 2'd2) shadow_low <= m_rdata;
            if (step == last_step) begin
              done  <= 1'b1;
              state <= FIN;
              if (op_q == 2'd0) value <= {m_rdata, shadow_low};
            end else begin
              step  <= step + 2'd1;
              state <= GAP;
            end
          end else if (timeout_hit) begin
            m_valid <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            state   <= FIN;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GAP: begin
          m_valid <= 1'b1;
          m_addr  <= sel_addr;
          m_wdata <= sel_wr ? sel_wdata : '0;
          m_wstrb <= sel_wr ? '1 : '0;
          tcnt    <= '0;
          state   <= REQ;
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_timer_reader.sv
// Directed bench for iob_timer_reader: a scripted IOb responder plus
// hand-computed expectations for sequences, latency, timeout and reset.
module tb_iob_timer_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic        cmd_ready;
  logic        done;
  logic        err;
  logic [63:0] value;
  logic        m_valid;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata = 32'h0;
  logic        m_ready = 1'b0;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_count = 0;

  // responder controls (written by the test) and state (written by responder)
  int          resp_lat = 1;
  logic        resp_stall = 1'b0;
  logic        spur_arm = 1'b0;
  logic        spur_used = 1'b0;
  logic [31:0] low_word = 32'h0;
  logic [31:0] high_word = 32'h0;
  int          rcnt = 0;
  int          last_held = 0;
  logic [15:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic [3:0]  log_wstrb[$];
  int          log_held[$];

  iob_timer_reader #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .done(done), .err(err), .value(value),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_count <= done_count + 1;

  // Responder: ready after resp_lat cycles of m_valid; one optional spurious
  // m_ready in the first idle-bus cycle after a completed transaction.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ready = 1'b0;
      rcnt = 0;
    end else if (m_valid) begin
      rcnt++;
      if (!resp_stall && rcnt == resp_lat + 1) begin
        m_ready = 1'b1;
        m_rdata = (m_addr == 16'd3) ? low_word : (m_addr == 16'd4) ? high_word : 32'hDEAD_BEEF;
        log_addr.push_back(m_addr);
        log_wdata.push_back(m_wdata);
        log_wstrb.push_back(m_wstrb);
        log_held.push_back(rcnt);
      end else begin
        m_ready = 1'b0;
      end
    end else begin
      if (rcnt > 0) last_held = rcnt;
      rcnt = 0;
      m_ready = spur_arm && !spur_used && (log_addr.size() > 0);
      if (m_ready) begin
        spur_used = 1'b1;
        m_rdata = 32'hFFFF_FFFF;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic startCmd(input logic [1:0] op);
    @(negedge clk);
    checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int bound, input int poke, output int lat, output logic e);
    lat = -1;
    e = 1'bx;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - acc_cyc;
        e = err;
        break;
      end
      if (poke > 0 && i == poke) begin cmd_valid = 1'b1; cmd_op = 2'd1; end
      if (poke > 0 && i == poke + 1) begin cmd_valid = 1'b0; cmd_op = 2'd0; end
    end
    cmd_valid = 1'b0;
    if (lat < 0) checkOutput("done_within_bound", 64'd0, 64'd1);
  endtask

  task automatic applyStimulus(input logic [1:0] op, input int poke, output int lat, output logic e);
    startCmd(op);
    waitDone(60, poke, lat, e);
  endtask

  task automatic checkSampleSeq(input string tag, input int base);
    logic [15:0] ea[4];
    logic [31:0] ed[4];
    logic [3:0]  es[4];
    ea = '{16'd2, 16'd2, 16'd3, 16'd4};
    ed = '{32'd1, 32'd0, 32'd0, 32'd0};
    es = '{4'hF, 4'hF, 4'h0, 4'h0};
    checkOutput({tag, "_txn_count"}, 64'(log_addr.size() - base), 64'd4);
    if (log_addr.size() - base == 4) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("%s_addr%0d", tag, k), 64'(log_addr[base+k]), 64'(ea[k]));
        checkOutput($sformatf("%s_wdata%0d", tag, k), 64'(log_wdata[base+k]), 64'(ed[k]));
        checkOutput($sformatf("%s_wstrb%0d", tag, k), 64'(log_wstrb[base+k]), 64'(es[k]));
        checkOutput($sformatf("%s_held%0d", tag, k), 64'(log_held[base+k]), 64'd2);
      end
    end
  endtask

  initial begin
    int lat;
    logic e;
    int base;
    int dc;

    repeat (3) @(negedge clk);
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_value", value, 64'd0);
    checkOutput("rst_m_wstrb", 64'(m_wstrb), 64'd0);
    checkOutput("rst_m_addr", 64'(m_addr), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: zero-wait SAMPLE_READ
    low_word = 32'h89AB_CDEF;
    high_word = 32'h0123_4567;
    resp_lat = 1;
    base = log_addr.size();
    applyStimulus(2'd0, 0, lat, e);
    checkOutput("t1_latency", 64'(lat), 64'd12);
    checkOutput("t1_err", 64'(e), 64'd0);
    checkOutput("t1_value", value, 64'h0123_4567_89AB_CDEF);
    checkSampleSeq("t1", base);

    // T2: ENABLE with 5 wait cycles
    resp_lat = 5;
    base = log_addr.size();
    applyStimulus(2'd1, 0, lat, e);
    checkOutput("t2_latency", 64'(lat), 64'd7);
    checkOutput("t2_err", 64'(e), 64'd0);
    checkOutput("t2_txn_count", 64'(log_addr.size() - base), 64'd1);
    if (log_addr.size() - base == 1) begin
      checkOutput("t2_addr", 64'(log_addr[base]), 64'd1);
      checkOutput("t2_wdata", 64'(log_wdata[base]), 64'd1);
      checkOutput("t2_wstrb", 64'(log_wstrb[base]), 64'hF);
      checkOutput("t2_held", 64'(log_held[base]), 64'd6);
    end
    checkOutput("t2_value_kept", value, 64'h0123_4567_89AB_CDEF);

    // T3: responder never ready, timeout after 8 cycles
    resp_stall = 1'b1;
    base = log_addr.size();
    applyStimulus(2'd0, 0, lat, e);
    @(negedge clk);
    checkOutput("t3_latency", 64'(lat), 64'd9);
    checkOutput("t3_err", 64'(e), 64'd1);
    checkOutput("t3_valid_cycles", 64'(last_held), 64'd8);
    checkOutput("t3_m_valid_low", 64'(m_valid), 64'd0);
    checkOutput("t3_value_kept", value, 64'h0123_4567_89AB_CDEF);
    checkOutput("t3_no_txn", 64'(log_addr.size() - base), 64'd0);
    resp_stall = 1'b0;
    resp_lat = 1;
    repeat (2) @(negedge clk);

    // T4: extra cmd_valid while busy and a spurious m_ready in a gap
    low_word = 32'h1111_2222;
    high_word = 32'h3333_4444;
    spur_arm = 1'b1;
    base = log_addr.size();
    dc = done_count;
    applyStimulus(2'd0, 3, lat, e);
    checkOutput("t4_latency", 64'(lat), 64'd12);
    checkOutput("t4_err", 64'(e), 64'd0);
    checkOutput("t4_value", value, 64'h3333_4444_1111_2222);
    checkSampleSeq("t4", base);
    repeat (20) @(negedge clk);
    checkOutput("t4_spurious_issued", 64'(spur_used), 64'd1);
    checkOutput("t4_no_queued_cmd", 64'(log_addr.size() - base), 64'd4);
    checkOutput("t4_single_done", 64'(done_count - dc), 64'd1);

    // T5: reset between LOW and HIGH reads, then SOFT_RESET
    base = log_addr.size();
    startCmd(2'd0);
    for (int i = 0; i < 40 && (log_addr.size() - base) < 3; i++) @(negedge clk);
    checkOutput("t5_low_read_reached", 64'(log_addr.size() - base), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    dc = done_count;
    checkOutput("t5_rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("t5_rst_done", 64'(done), 64'd0);
    checkOutput("t5_rst_value", value, 64'd0);
    checkOutput("t5_rst_m_addr", 64'(m_addr), 64'd0);
    checkOutput("t5_rst_m_wstrb", 64'(m_wstrb), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("t5_no_done", 64'(done_count - dc), 64'd0);
    checkOutput("t5_no_high_read", 64'(log_addr.size() - base), 64'd3);
    base = log_addr.size();
    applyStimulus(2'd3, 0, lat, e);
    checkOutput("t5_latency", 64'(lat), 64'd6);
    checkOutput("t5_err", 64'(e), 64'd0);
    checkOutput("t5_txn_count", 64'(log_addr.size() - base), 64'd2);
    if (log_addr.size() - base == 2) begin
      checkOutput("t5_addr0", 64'(log_addr[base]), 64'd0);
      checkOutput("t5_wdata0", 64'(log_wdata[base]), 64'd1);
      checkOutput("t5_addr1", 64'(log_addr[base+1]), 64'd0);
      checkOutput("t5_wdata1", 64'(log_wdata[base+1]), 64'd0);
    end
    checkOutput("t5_value_zero", value, 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
